// File: rtl/mux6_sched_pkg.sv
// Shared definitions for the six-way round-robin mux scheduler.
//   N_REQ    : number of requesters / mux inputs
//   SEL_W    : width of the mux select
//   state_t  : scheduler FSM states
//   wrap_inc : next index modulo N_REQ
package mux6_sched_pkg;

  localparam int N_REQ = 6;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/mux6_rr_scheduler_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : scan start index (0..5)
//   idx   : first set request at or after ptr, wrapping 5 -> 0
//   found : high when any request is set
module rr_pick6
  import mux6_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [3:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = 4'(ptr) + 4'(i);
      if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
      if (!found && req[pos[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux6_rr_scheduler.sv
// Round-robin scheduler sharing one 6:1 single-bit mux among six requesters.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request
//   in_bit   : per-requester data bit (mux inputs)
//   gnt      : registered one-hot grant, zero when idle
//   sel      : registered mux select of the granted requester
//   y        : registered mux output, holds when no valid data
//   y_valid  : y carries a bit from a granted, still-requesting source
module mux6_rr_scheduler
  import mux6_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in_bit,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_valid
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] gnt_n;
  logic [SEL_W-1:0] sel_n;

  logic             release_now;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             live;

  // A single picker serves both IDLE and release: on release it scans from
  // owner+1 so the new grant lands on the same edge without a bubble.
  assign release_now = (state == BUSY) && (!req[sel] || (hold_cnt == HOLD_LIM));
  assign pick_ptr    = release_now ? wrap_inc(sel) : ptr;

  rr_pick6 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    hold_cnt_n = hold_cnt;
    gnt_n      = gnt;
    sel_n      = sel;
    unique case (state)
      IDLE: begin
        gnt_n = '0;
        if (pick_found) begin
          gnt_n      = N_REQ'(1) << pick_idx;
          sel_n      = pick_idx;
          hold_cnt_n = CNT_W'(1);
          state_n    = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_n = pick_ptr;
          if (pick_found) begin
            gnt_n      = N_REQ'(1) << pick_idx;
            sel_n      = pick_idx;
            hold_cnt_n = CNT_W'(1);
          end else begin
            gnt_n      = '0;
            hold_cnt_n = '0;
            state_n    = IDLE;
          end
        end else begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_cnt_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
    end
  end

  // y only loads when the new sample is valid, so it holds across idle gaps.
  assign live = |(gnt & req);

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= live;
      if (live) y <= in_bit[sel];
    end
  end

endmodule

// File: tb/tb_mux6_rr_scheduler.sv
module tb_mux6_rr_scheduler;
  import mux6_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] req;
  logic [5:0] in_bit;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       y;
  logic       y_valid;

  int errors = 0;
  int checks = 0;

  mux6_rr_scheduler #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in_bit  (in_bit),
    .gnt     (gnt),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] in_v;
    logic [5:0] eg;
    int         prev;

    // Reset held two cycles with every requester active.
    rst = 1'b1; req = 6'h3F; in_bit = 6'h00;
    for (int r = 0; r < 2; r++) begin
      tick();
      check("rst_gnt", 8'(gnt), 8'h00);
      check("rst_sel", 8'(sel), 8'h0);
      check("rst_y", 8'(y), 8'h0);
      check("rst_yv", 8'(y_valid), 8'h0);
    end

    // Rotation 0..5,0 with four cycles each; first grant one edge after reset.
    in_v   = 6'b101101;
    in_bit = in_v;
    rst    = 1'b0;
    prev   = 0;
    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        eg = 6'd1 << (k % 6);
        check("rot_gnt", 8'(gnt), 8'(eg));
        check("rot_sel", 8'(sel), 8'(k % 6));
        if (k == 0 && c == 0) begin
          check("rot_yv_first", 8'(y_valid), 8'h0);
        end else begin
          check("rot_yv", 8'(y_valid), 8'h1);
          check("rot_y", 8'(y), 8'(in_v[prev]));
        end
        prev = k % 6;
      end
    end

    // Early drop: 0 expires, 2 wins (scan from 1), then drops after one cycle.
    req = 6'h14;
    tick();
    check("drop_gnt2", 8'(gnt), 8'h04);
    check("drop_sel2", 8'(sel), 8'h2);
    req = 6'h10;
    tick();
    check("drop_gnt4", 8'(gnt), 8'h10);
    check("drop_sel4", 8'(sel), 8'h4);
    check("drop_yv0", 8'(y_valid), 8'h0);
    tick();
    check("drop_yv1", 8'(y_valid), 8'h1);
    check("drop_y", 8'(y), 8'(in_v[4]));

    // Reset while 4 owns the mux.
    rst = 1'b1; req = 6'h30;
    tick();
    check("mrst_gnt", 8'(gnt), 8'h00);
    check("mrst_sel", 8'(sel), 8'h0);
    check("mrst_ptr", 8'(dut.ptr), 8'h0);
    check("mrst_state", 8'(dut.state), 8'(IDLE));
    check("mrst_yv", 8'(y_valid), 8'h0);
    rst = 1'b0;
    tick();
    check("mrst_gnt4", 8'(gnt), 8'h10);
    check("mrst_sel4", 8'(sel), 8'h4);

    // Single requester 3: hits the hold limit and is re-granted with no gap.
    req = 6'h08; in_bit = 6'h08;
    tick();
    check("hold_gnt_first", 8'(gnt), 8'h08);
    check("hold_sel_first", 8'(sel), 8'h3);
    check("hold_yv_first", 8'(y_valid), 8'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("hold_gnt", 8'(gnt), 8'h08);
      check("hold_sel", 8'(sel), 8'h3);
      check("hold_y", 8'(y), 8'h1);
      check("hold_yv", 8'(y_valid), 8'h1);
    end
    check("hold_regrant_cnt", 8'(dut.hold_cnt), 8'h1);

    // All requests drop: idle, y keeps its last value despite in_bit changing.
    req = 6'h00; in_bit = 6'h00;
    tick();
    check("idle_gnt", 8'(gnt), 8'h00);
    check("idle_ptr", 8'(dut.ptr), 8'h4);
    tick();
    check("idle_gnt2", 8'(gnt), 8'h00);
    check("idle_yv", 8'(y_valid), 8'h0);
    check("idle_y_hold", 8'(y), 8'h1);
    check("idle_state", 8'(dut.state), 8'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
